// File: rtl/stream_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo_if
//  Brief    : Valid/ready write and read channels plus fill level for stream_fifo.
//  Revision : 1.0  initial release
// ============================================================================
interface stream_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH + 1);

  logic             wr_valid_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             wr_ready_o;
  logic             rd_valid_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_ready_i;
  logic [c_CW-1:0]  count_o;

  // FIFO side
  modport slave (
    input  wr_valid_i, wr_data_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_data_o, count_o
  );

  // Producer/consumer side
  modport master (
    output wr_valid_i, wr_data_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo
//  Brief    : Show-ahead valid/ready FIFO, power-of-two depth, async reset.
//  Revision : 1.0  initial release
// ============================================================================
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic      clk_i,
  input  wire logic      rst_i,
  stream_fifo_if.slave   s
);
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  generate
    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("stream_fifo: WIDTH must be >= 1 and DEPTH a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  logic w_wr_ready;
  logic w_rd_valid;
  logic w_push;
  logic w_pop;

  // Flags come from the registered count only, so rd_ready_i never reaches wr_ready_o.
  assign w_wr_ready = (r_count != c_FULL);
  assign w_rd_valid = (r_count != '0);
  assign w_push     = s.wr_valid_i && w_wr_ready;
  assign w_pop      = w_rd_valid && s.rd_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; gating on rst_i keeps writes out while reset is held.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem[r_wr_ptr] <= s.wr_data_i;
    end
  end

  assign s.wr_ready_o = w_wr_ready;
  assign s.rd_valid_o = w_rd_valid;
  assign s.rd_data_o  = r_mem[r_rd_ptr];
  assign s.count_o    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fifo
//  Brief    : Self-checking bench for stream_fifo (WIDTH=8, DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_fifo;
  localparam int c_WIDTH = 8;
  localparam int c_DEPTH = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [7:0] sb[$];

  stream_fifo_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) bus ();

  stream_fifo #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    int         exp_cnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock of stimulus; the queue model decides push/pop from its own fill level.
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr);
    bit push;
    bit pop;
    bus.wr_valid_i = wv;
    bus.wr_data_i  = wd;
    bus.rd_ready_i = rr;
    push = wv && (sb.size() != c_DEPTH);
    pop  = rr && (sb.size() != 0);
    if (pop) chk("head_data", int'(bus.rd_data_o), int'(sb[0]));
    @(posedge clk);
    #1;
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back(wd);
    chk("count",    int'(bus.count_o),    sb.size());
    chk("rd_valid", int'(bus.rd_valid_o), int'(sb.size() != 0));
    chk("wr_ready", int'(bus.wr_ready_o), int'(sb.size() != c_DEPTH));
  endtask

  initial begin
    vec_t vecs[$];
    n_chk = 0;
    n_err = 0;

    // fill, refused push, drain, empty pop, refill, full+pop, drain
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 2});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 3});
    vecs.push_back('{1'b1, 8'h44, 1'b0, 4});
    vecs.push_back('{1'b1, 8'h55, 1'b0, 4});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 0});
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 2});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 3});
    vecs.push_back('{1'b1, 8'h44, 1'b0, 4});
    vecs.push_back('{1'b1, 8'h99, 1'b1, 3});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 0});

    rst = 1'b1;
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i  = '0;
    bus.rd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",    int'(bus.count_o),    0);
    chk("rst_rd_valid", int'(bus.rd_valid_o), 0);
    chk("rst_wr_ready", int'(bus.wr_ready_o), 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].wv, vecs[i].wd, vecs[i].rr);
      chk($sformatf("vec%0d_count", i), int'(bus.count_o), vecs[i].exp_cnt);
    end

    // Write-to-read latency from empty
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'hA5;
    #1;
    chk("lat_pre_valid", int'(bus.rd_valid_o), 0);
    cycle(1'b1, 8'hA5, 1'b0);
    chk("lat_data",  int'(bus.rd_data_o),  8'hA5);
    chk("lat_valid", int'(bus.rd_valid_o), 1);
    cycle(1'b0, 8'h00, 1'b1);

    // Streaming through several pointer wraps at a steady fill of two
    cycle(1'b1, 8'd0, 1'b0);
    cycle(1'b1, 8'd1, 1'b0);
    for (int i = 2; i < 20; i++) begin
      cycle(1'b1, 8'(i), 1'b1);
      chk("stream_count", int'(bus.count_o), 2);
    end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("stream_empty", int'(bus.rd_valid_o), 0);

    // Asynchronous reset mid-stream at count 3
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    chk("pre_rst_count", int'(bus.count_o), 3);
    bus.wr_valid_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count",    int'(bus.count_o),    0);
    chk("arst_rd_valid", int'(bus.rd_valid_o), 0);
    chk("arst_wr_ready", int'(bus.wr_ready_o), 1);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'hEE;
    bus.rd_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_count", int'(bus.count_o),    0);
    chk("rst_hold_valid", int'(bus.rd_valid_o), 0);
    rst = 1'b0;
    sb.delete();
    cycle(1'b1, 8'h7E, 1'b0);
    chk("post_rst_data", int'(bus.rd_data_o), 8'h7E);
    cycle(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
